dds_par2ser: RTL and testbench

- AXI-Stream slave that consumes the wide multi-channel sample word produced by the parallel DDS on its m_axis port.
- Serializes the word into one DATA_WIDTH sample per accepted output beat, lane 0 first.
- Used to drive single-lane consumers (narrow DAC path, debug capture, checkers) from the parallel DDS output.
- Provides tlast per wide word so downstream logic can realign to DDS word boundaries.

---
 rtl/dds_pkg.sv | 23 ++
 rtl/dds_par2ser_if.sv | 26 ++
 rtl/dds_lane_mux.sv | 21 ++
 rtl/dds_par2ser.sv | 125 ++++++++++++
 tb/tb_dds_par2ser.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS serializer slice: default widths, state
// encoding and a constant-foldable clog2.
package dds_pkg;

  localparam int unsigned DDS_CHANNEL_NUM = 8;
  localparam int unsigned DDS_DATA_WIDTH  = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Number of bits needed to index n items (n >= 2).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = 32'(i) + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dds_par2ser_if.sv
// Stream bundle between the parallel DDS output and the single-lane consumer.
// slave = serializer side, master = the side driving/observing it.
interface dds_par2ser_if #(
  parameter int unsigned CHANNEL_NUM = dds_pkg::DDS_CHANNEL_NUM,
  parameter int unsigned DATA_WIDTH  = dds_pkg::DDS_DATA_WIDTH
);

  logic [CHANNEL_NUM*DATA_WIDTH-1:0] s_axis_tdata;
  logic                              s_axis_tvalid;
  logic                              s_axis_tready;
  logic [DATA_WIDTH-1:0]             m_axis_tdata;
  logic                              m_axis_tvalid;
  logic                              m_axis_tready;
  logic                              m_axis_tlast;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

endinterface

// File: rtl/dds_lane_mux.sv
// CHANNEL_NUM:1 combinational selector picking lane[sel_i] out of a wide word.
module dds_lane_mux
  import dds_pkg::*;
#(
  parameter int unsigned CHANNEL_NUM = DDS_CHANNEL_NUM,
  parameter int unsigned DATA_WIDTH  = DDS_DATA_WIDTH,
  parameter int unsigned IDX_W       = clog2(CHANNEL_NUM)
) (
  input  logic [CHANNEL_NUM*DATA_WIDTH-1:0] lanes_i,
  input  logic [IDX_W-1:0]                  sel_i,
  output logic [DATA_WIDTH-1:0]             lane_c
);

  always_comb begin
    lane_c = '0;
    for (int k = 0; k < int'(CHANNEL_NUM); k++) begin
      if (sel_i == IDX_W'(k)) lane_c = lanes_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/dds_par2ser.sv
// Serializes the wide multi-lane DDS word into one sample per beat, lane 0 first,
// with tlast on the final lane. Define DDS_PAR2SER_STATUS_EN for word_cnt/underrun.
module dds_par2ser
  import dds_pkg::*;
#(
  parameter int unsigned CHANNEL_NUM = DDS_CHANNEL_NUM,
  parameter int unsigned DATA_WIDTH  = DDS_DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  dds_par2ser_if.slave  bus
`ifdef DDS_PAR2SER_STATUS_EN
  ,
  output logic [31:0]   word_cnt,
  output logic          underrun
`endif
);

  localparam int unsigned WORD_W = CHANNEL_NUM * DATA_WIDTH;
  localparam int unsigned IDX_W  = clog2(CHANNEL_NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNEL_NUM - 1);

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  hold_q,  hold_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;

  logic               last_c;
  logic               s_rdy_c;
  logic               s_hs_c;
  logic               m_hs_c;
  logic [DATA_WIDTH-1:0] lane_c;

  assign last_c  = (idx_q == LAST_IDX);
  // Ready when empty, or when the final lane leaves this cycle (zero-bubble reload).
  assign s_rdy_c = !rst_n && ((state_q == ST_IDLE) ||
                              (last_c && bus.m_axis_tready));
  assign s_hs_c  = bus.s_axis_tvalid && s_rdy_c;
  assign m_hs_c  = (state_q == ST_SHIFT) && bus.m_axis_tready;

  assign bus.s_axis_tready = s_rdy_c;
  assign bus.m_axis_tvalid = (state_q == ST_SHIFT);
  assign bus.m_axis_tlast  = (state_q == ST_SHIFT) && last_c;
  assign bus.m_axis_tdata  = lane_c;

  dds_lane_mux #(
    .CHANNEL_NUM (CHANNEL_NUM),
    .DATA_WIDTH  (DATA_WIDTH),
    .IDX_W       (IDX_W)
  ) u_lane_mux (
    .lanes_i (hold_q),
    .sel_i   (idx_q),
    .lane_c  (lane_c)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (s_hs_c) begin
          hold_d  = bus.s_axis_tdata;
          idx_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (m_hs_c) begin
          if (!last_c) begin
            idx_d = idx_q + IDX_W'(1);
          end else if (s_hs_c) begin
            hold_d = bus.s_axis_tdata;
            idx_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // rst_n is active-high in this codebase.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
    end
  end

`ifdef DDS_PAR2SER_STATUS_EN
  logic [31:0] word_cnt_q, word_cnt_d;
  logic        underrun_q, underrun_d;
  logic        break_q,    break_d;

  // A break is a final-lane beat with no follow-on word; it counts as underrun
  // only if the consumer is still asking for data on the next cycle.
  always_comb begin
    word_cnt_d = word_cnt_q + 32'(s_hs_c);
    break_d    = m_hs_c && last_c && !s_hs_c;
    underrun_d = underrun_q || (break_q && bus.m_axis_tready);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      word_cnt_q <= '0;
      underrun_q <= 1'b0;
      break_q    <= 1'b0;
    end else begin
      word_cnt_q <= word_cnt_d;
      underrun_q <= underrun_d;
      break_q    <= break_d;
    end
  end

  assign word_cnt = word_cnt_q;
  assign underrun = underrun_q;
`endif

endmodule

// File: tb/tb_dds_par2ser.sv
// Bench for dds_par2ser: directed scenarios plus randomized traffic checked
// against a beat-queue model of the serializer.
module tb_dds_par2ser;

  localparam int unsigned CH = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned WW = CH * DW;

  typedef logic [WW-1:0] word_t;
  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic clk;
  logic rst_n;

  dds_par2ser_if #(.CHANNEL_NUM(CH), .DATA_WIDTH(DW)) bus ();

`ifdef DDS_PAR2SER_STATUS_EN
  logic [31:0] word_cnt;
  logic        underrun;
`endif

  dds_par2ser #(.CHANNEL_NUM(CH), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DDS_PAR2SER_STATUS_EN
    ,
    .word_cnt (word_cnt),
    .underrun (underrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic word_t mk_word(input int unsigned base);
    word_t w;
    w = '0;
    for (int k = 0; k < int'(CH); k++) w[k*DW +: DW] = DW'(base + 32'(k));
    return w;
  endfunction

  // Model: a FIFO of the beats still owed downstream.
  beat_t q[$];
  logic  exp_rdy, s_hs, m_hs;
  int unsigned m_cnt;
  logic  m_und, m_brk;

  always @(negedge clk) begin
    if (rst_n) begin
      q.delete();
      m_cnt = 0; m_und = 1'b0; m_brk = 1'b0;
      chk("rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
      chk("rst_m_tdata",  64'(bus.m_axis_tdata),  64'd0);
      chk("rst_m_tlast",  64'(bus.m_axis_tlast),  64'd0);
      chk("rst_s_tready", 64'(bus.s_axis_tready), 64'd0);
`ifdef DDS_PAR2SER_STATUS_EN
      chk("rst_word_cnt", 64'(word_cnt), 64'd0);
      chk("rst_underrun", 64'(underrun), 64'd0);
`endif
    end else begin
      exp_rdy = (q.size() == 0) || (q.size() == 1 && bus.m_axis_tready);
      chk("mon_m_tvalid", 64'(bus.m_axis_tvalid), 64'(q.size() != 0));
      chk("mon_s_tready", 64'(bus.s_axis_tready), 64'(exp_rdy));
      if (q.size() != 0) begin
        chk("mon_m_tdata", 64'(bus.m_axis_tdata), 64'(q[0].d));
        chk("mon_m_tlast", 64'(bus.m_axis_tlast), 64'(q[0].l));
      end
`ifdef DDS_PAR2SER_STATUS_EN
      chk("mon_word_cnt", 64'(word_cnt), 64'(m_cnt));
      chk("mon_underrun", 64'(underrun), 64'(m_und));
`endif
      s_hs = bus.s_axis_tvalid && exp_rdy;
      m_hs = (q.size() != 0) && bus.m_axis_tready;
      if (m_brk && bus.m_axis_tready) m_und = 1'b1;
      m_brk = m_hs && q[0].l && !s_hs;
      if (m_hs) void'(q.pop_front());
      if (s_hs) begin
        m_cnt = m_cnt + 1;
        for (int k = 0; k < int'(CH); k++) begin
          beat_t b;
          b.d = bus.s_axis_tdata[k*DW +: DW];
          b.l = (k == int'(CH) - 1);
          q.push_back(b);
        end
      end
    end
  end

  // Called and returns at #1 after a rising edge.
  task automatic send_word(input word_t w);
    int n;
    n = 0;
    bus.s_axis_tdata  = w;
    bus.s_axis_tvalid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.s_axis_tready && n < 200);
    if (!bus.s_axis_tready) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    cycles(2);
    rst_n = 1'b0;
    cycles(1);
  endtask

  initial begin
    rst_n = 1'b1;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.m_axis_tready = 1'b1;
    cycles(3);
    chk("reset_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    chk("reset_s_tready", 64'(bus.s_axis_tready), 64'd0);
    rst_n = 1'b0;
    cycles(1);
    chk("idle_s_tready", 64'(bus.s_axis_tready), 64'd1);

    // Single word, full rate
    send_word(mk_word(0));
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      chk("single_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
      chk("single_tdata",  64'(bus.m_axis_tdata),  64'(b));
      chk("single_tlast",  64'(bus.m_axis_tlast),  64'(b == 7));
    end
    @(negedge clk);
    chk("single_done_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    cycles(2);

    // Back-to-back A then B with no bubble
    send_word(mk_word(0));
    bus.s_axis_tdata  = mk_word(32'h10);
    bus.s_axis_tvalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("b2b_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
      chk("b2b_tdata",  64'(bus.m_axis_tdata),  64'(i < 8 ? i : 32'h10 + i - 8));
      chk("b2b_s_tready", 64'(bus.s_axis_tready), 64'(i == 7 || i == 15));
      if (i == 7) begin
        @(posedge clk); #1;
        bus.s_axis_tvalid = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_done_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    cycles(2);

    // Backpressure on lane 3
    send_word(mk_word(0));
    cycles(3);
    bus.m_axis_tready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_tdata", 64'(bus.m_axis_tdata), 64'd3);
      chk("stall_tlast", 64'(bus.m_axis_tlast), 64'd0);
      chk("stall_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
    end
    @(posedge clk); #1;
    bus.m_axis_tready = 1'b1;
    for (int k = 3; k < 8; k++) begin
      @(negedge clk);
      chk("resume_tdata", 64'(bus.m_axis_tdata), 64'(k));
    end
    @(negedge clk);
    chk("stall_done_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    cycles(1);

    // Reset mid-frame after lane 2 is accepted
    send_word(mk_word(32'h30));
    cycles(3);
    rst_n = 1'b1;
    #1;
    chk("arst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    chk("arst_tdata",  64'(bus.m_axis_tdata),  64'd0);
    chk("arst_s_tready", 64'(bus.s_axis_tready), 64'd0);
    cycles(2);
    rst_n = 1'b0;
    #1;
    chk("post_rst_s_tready", 64'(bus.s_axis_tready), 64'd1);
    chk("post_rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    cycles(1);
    send_word(mk_word(32'h40));
    @(negedge clk);
    chk("post_rst_lane0", 64'(bus.m_axis_tdata), 64'h40);
    cycles(8);

    // Idle gap of 5 cycles between words
    send_word(mk_word(32'h50));
    cycles(8);
    repeat (4) begin
      @(negedge clk);
      chk("gap_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
      @(posedge clk); #1;
    end
    send_word(mk_word(32'h60));
    @(negedge clk);
    chk("gap_lane0_tdata", 64'(bus.m_axis_tdata), 64'h60);
    chk("gap_lane0_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
    cycles(9);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      if (c == 1000 || c == 2200) begin
        rst_n = 1'b1;
        cycles(2);
        rst_n = 1'b0;
      end
      bus.s_axis_tvalid = ($urandom_range(0, 99) < 60);
      bus.s_axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
      bus.m_axis_tready = ($urandom_range(0, 99) < 75);
      cycles(1);
    end
    bus.s_axis_tvalid = 1'b0;
    bus.m_axis_tready = 1'b1;
    cycles(10);

`ifdef DDS_PAR2SER_STATUS_EN
    // Three contiguous words, then the stream breaks while downstream is ready
    do_reset();
    send_word(mk_word(32'h100));
    send_word(mk_word(32'h200));
    send_word(mk_word(32'h300));
    chk("stat_cnt_3", 64'(word_cnt), 64'd3);
    chk("stat_und_0", 64'(underrun), 64'd0);
    cycles(10);
    chk("stat_cnt_hold", 64'(word_cnt), 64'd3);
    chk("stat_und_set", 64'(underrun), 64'd1);
    cycles(5);
    chk("stat_und_sticky", 64'(underrun), 64'd1);
    do_reset();
    chk("stat_cnt_clr", 64'(word_cnt), 64'd0);
    chk("stat_und_clr", 64'(underrun), 64'd0);
`else
    do_reset();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
